// File: rtl/irq_ctrl_pkg.sv
// Shared codes for the interrupt/trap controller: decoder states, cause codes,
// CSR addresses, FSM encodings and the vector address helper.
package irq_ctrl_pkg;

  typedef logic [3:0] cause_t;

  localparam logic [3:0] ST_TRAP  = 4'd0;
  localparam logic [3:0] ST_EXECM = 4'd8;

  localparam cause_t CAUSE_SYSCALL = 4'd8;
  localparam cause_t CAUSE_FAULT   = 4'd9;

  localparam logic [1:0] CSR_MASK    = 2'd0;
  localparam logic [1:0] CSR_PENDING = 2'd1;
  localparam logic [1:0] CSR_CTRL    = 2'd2;
  localparam logic [1:0] CSR_CAUSE   = 2'd3;

  localparam logic [1:0] FSM_IDLE    = 2'd0;
  localparam logic [1:0] FSM_PEND    = 2'd1;
  localparam logic [1:0] FSM_SERVICE = 2'd2;

  // Handler address wraps at 16 bits.
  function automatic logic [15:0] vec_addr(input logic [15:0] base,
                                           input logic [15:0] stride,
                                           input cause_t      c);
    return base + 16'(c) * stride;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority cause encoder: fault > SYSCALL > external line 0 .. NIRQ-1.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int NIRQ = 8
) (
  input  logic            fault,
  input  logic            swpend,
  input  logic [NIRQ-1:0] req,
  output logic            valid,
  output cause_t          cause
);

  always_comb begin
    valid = fault | swpend | (|req);
    cause = '0;
    // Descend so the lowest-numbered active line is the last assignment.
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (req[i]) cause = 4'(i);
    end
    if (swpend) cause = CAUSE_SYSCALL;
    if (fault)  cause = CAUSE_FAULT;
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt and trap controller: latches line edges, SYSCALL and faults,
// arbitrates from IDLE, hands one request at a time to the decoder.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          NIRQ       = 8,
  parameter logic [15:0] VEC_BASE   = 16'h0010,
  parameter int          VEC_STRIDE = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq_in,
  input  logic [3:0]      state,
  input  logic            SYSCALL,
  input  logic            RETI,
  input  logic            fault_in,
  input  logic            csr_we,
  input  logic [1:0]      csr_addr,
  input  logic [7:0]      csr_wdata,
  output logic [7:0]      csr_rdata,
  output logic            irq_r,
  output logic            fault_r,
  output logic [15:0]     vector,
  output logic            ie,
  output logic            double_fault
);

  logic [NIRQ-1:0] irq_prev_q, pend_q, pend_d, mask_q, mask_d;
  logic [NIRQ-1:0] rise, w1c, take_clr, req;
  logic            swpend_q, swpend_d, sw_take;
  logic            ie_q, ie_d, irq_r_q, irq_r_d, fault_r_q, fault_r_d, df_q, df_d;
  cause_t          cause_q, cause_d, enc_cause;
  logic            enc_valid;
  logic [15:0]     vector_q, vector_d;
  logic [1:0]      fsm_q, fsm_d;
  logic [7:0]      pend_ext, mask_ext;

  assign req = pend_q & mask_q & {NIRQ{ie_q}};

  irq_prio_enc #(.NIRQ(NIRQ)) u_enc (
    .fault  (fault_in),
    .swpend (swpend_q),
    .req    (req),
    .valid  (enc_valid),
    .cause  (enc_cause)
  );

  always_comb begin
    rise     = irq_in & ~irq_prev_q;
    w1c      = '0;
    take_clr = '0;
    sw_take  = 1'b0;
    mask_d   = mask_q;
    ie_d     = ie_q;
    fsm_d    = fsm_q;
    irq_r_d  = irq_r_q;
    cause_d  = cause_q;
    vector_d = vector_q;
    df_d     = df_q;

    if (csr_we) begin
      case (csr_addr)
        CSR_MASK:    mask_d = csr_wdata[NIRQ-1:0];
        CSR_PENDING: w1c    = csr_wdata[NIRQ-1:0];
        CSR_CTRL:    ie_d   = csr_wdata[0];
        default:     ;
      endcase
    end

    // FSM effects are applied after CSR writes so RETI/take/fault override CTRL.
    if (fault_in) begin
      fsm_d    = FSM_SERVICE;
      cause_d  = CAUSE_FAULT;
      irq_r_d  = 1'b0;
      ie_d     = 1'b0;
      vector_d = vec_addr(VEC_BASE, 16'(VEC_STRIDE), CAUSE_FAULT);
      if (fsm_q == FSM_SERVICE) df_d = 1'b1;
    end else begin
      case (fsm_q)
        FSM_IDLE: begin
          if (enc_valid) begin
            fsm_d   = FSM_PEND;
            cause_d = enc_cause;
            irq_r_d = 1'b1;
          end
        end
        FSM_PEND: begin
          if (state == ST_TRAP && irq_r_q) begin
            fsm_d    = FSM_SERVICE;
            irq_r_d  = 1'b0;
            ie_d     = 1'b0;
            vector_d = vec_addr(VEC_BASE, 16'(VEC_STRIDE), cause_q);
            sw_take  = (cause_q == CAUSE_SYSCALL);
            for (int i = 0; i < NIRQ; i++) take_clr[i] = (cause_q == 4'(i));
          end
        end
        FSM_SERVICE: begin
          if (state == ST_EXECM && RETI) begin
            fsm_d = FSM_IDLE;
            ie_d  = 1'b1;
          end
        end
        default: fsm_d = FSM_IDLE;
      endcase
    end

    // New edges win over take-clear and W1C on the same bit.
    pend_d    = (pend_q & ~take_clr & ~w1c) | rise;
    swpend_d  = (swpend_q & ~sw_take) | (state == ST_EXECM && SYSCALL);
    fault_r_d = fault_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_prev_q <= '0;
      pend_q     <= '0;
      mask_q     <= '0;
      swpend_q   <= 1'b0;
      ie_q       <= 1'b0;
      irq_r_q    <= 1'b0;
      fault_r_q  <= 1'b0;
      df_q       <= 1'b0;
      cause_q    <= '0;
      vector_q   <= VEC_BASE;
      fsm_q      <= FSM_IDLE;
    end else begin
      irq_prev_q <= irq_in;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      swpend_q   <= swpend_d;
      ie_q       <= ie_d;
      irq_r_q    <= irq_r_d;
      fault_r_q  <= fault_r_d;
      df_q       <= df_d;
      cause_q    <= cause_d;
      vector_q   <= vector_d;
      fsm_q      <= fsm_d;
    end
  end

  always_comb begin
    pend_ext = '0;
    mask_ext = '0;
    pend_ext[NIRQ-1:0] = pend_q;
    mask_ext[NIRQ-1:0] = mask_q;
    case (csr_addr)
      CSR_MASK:    csr_rdata = mask_ext;
      CSR_PENDING: csr_rdata = pend_ext;
      CSR_CTRL:    csr_rdata = {7'b0, ie_q};
      CSR_CAUSE:   csr_rdata = {df_q, 3'b0, cause_q};
      default:     csr_rdata = '0;
    endcase
  end

  assign irq_r        = irq_r_q;
  assign fault_r      = fault_r_q;
  assign vector       = vector_q;
  assign ie           = ie_q;
  assign double_fault = df_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: hand-computed expectations checked with
// immediate assertions one cycle step at a time.
module tb_irq_ctrl;

  logic        clk, reset;
  logic [7:0]  irq_in;
  logic [3:0]  state;
  logic        SYSCALL, RETI, fault_in, csr_we;
  logic [1:0]  csr_addr;
  logic [7:0]  csr_wdata, csr_rdata;
  logic        irq_r, fault_r, ie, double_fault;
  logic [15:0] vector;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  irq_ctrl #(.NIRQ(8), .VEC_BASE(16'h0010), .VEC_STRIDE(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .irq_in       (irq_in),
    .state        (state),
    .SYSCALL      (SYSCALL),
    .RETI         (RETI),
    .fault_in     (fault_in),
    .csr_we       (csr_we),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .csr_rdata    (csr_rdata),
    .irq_r        (irq_r),
    .fault_r      (fault_r),
    .vector       (vector),
    .ie           (ie),
    .double_fault (double_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_csr(input string tag, input logic [1:0] a, input logic [7:0] exp);
    csr_addr = a;
    #1;
    chk(tag, {8'h00, csr_rdata}, {8'h00, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [7:0] d);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic reti();
    state = 4'd8; RETI = 1'b1;
    tick();
    state = 4'd7; RETI = 1'b0;
  endtask

  initial begin
    reset = 1'b0; irq_in = '0; state = 4'd7; SYSCALL = 0; RETI = 0;
    fault_in = 0; csr_we = 0; csr_addr = 0; csr_wdata = 0;
    #12;
    chk("rst_irq_r", {15'b0, irq_r}, 16'h0);
    chk("rst_fault_r", {15'b0, fault_r}, 16'h0);
    chk("rst_ie", {15'b0, ie}, 16'h0);
    chk("rst_df", {15'b0, double_fault}, 16'h0);
    chk("rst_vector", vector, 16'h0010);
    chk_csr("rst_mask", 2'd0, 8'h00);
    chk_csr("rst_pending", 2'd1, 8'h00);
    chk_csr("rst_cause", 2'd3, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    // Single masked-in line 2.
    csr_wr(2'd0, 8'h04);
    csr_wr(2'd2, 8'h01);
    chk("t1_ie_set", {15'b0, ie}, 16'h1);
    irq_in = 8'h04;
    tick();
    chk_csr("t1_pend", 2'd1, 8'h04);
    chk("t1_irq_r_not_yet", {15'b0, irq_r}, 16'h0);
    tick();
    chk("t1_irq_r", {15'b0, irq_r}, 16'h1);
    chk_csr("t1_cause", 2'd3, 8'h02);
    state = 4'd8;
    tick();
    chk("t1_hold_pend", {15'b0, irq_r}, 16'h1);
    state = 4'd0;
    tick();
    state = 4'd7;
    chk("t1_irq_r_drop", {15'b0, irq_r}, 16'h0);
    chk("t1_vector", vector, 16'h0018);
    chk("t1_ie_clr", {15'b0, ie}, 16'h0);
    chk_csr("t1_pend_clr", 2'd1, 8'h00);
    reti();
    chk("t1_reti_ie", {15'b0, ie}, 16'h1);
    irq_in = '0;
    tick();

    // Lines 5 and 1 together; 1 wins, 5 follows after RETI.
    csr_wr(2'd0, 8'hFF);
    irq_in = 8'h22;
    tick();
    chk_csr("t2_pend", 2'd1, 8'h22);
    tick();
    chk("t2_irq_r", {15'b0, irq_r}, 16'h1);
    chk_csr("t2_cause1", 2'd3, 8'h01);
    state = 4'd0;
    tick();
    state = 4'd7;
    chk("t2_vector1", vector, 16'h0014);
    chk_csr("t2_pend5", 2'd1, 8'h20);
    reti();
    chk("t2_reti_idle", {15'b0, irq_r}, 16'h0);
    tick();
    chk("t2_irq_r5", {15'b0, irq_r}, 16'h1);
    chk_csr("t2_cause5", 2'd3, 8'h05);
    state = 4'd0;
    tick();
    state = 4'd7;
    chk("t2_vector5", vector, 16'h0024);
    reti();
    irq_in = '0;
    tick();

    // SYSCALL with interrupts disabled.
    csr_wr(2'd2, 8'h00);
    state = 4'd8; SYSCALL = 1'b1;
    tick();
    state = 4'd7; SYSCALL = 1'b0;
    chk("t3_irq_r_not_yet", {15'b0, irq_r}, 16'h0);
    tick();
    chk("t3_irq_r", {15'b0, irq_r}, 16'h1);
    chk_csr("t3_cause", 2'd3, 8'h08);
    state = 4'd0;
    tick();
    state = 4'd7;
    chk("t3_vector", vector, 16'h0030);
    reti();
    csr_wr(2'd2, 8'h00);

    // W1C racing a new edge on the same bit.
    irq_in = 8'h06;
    tick();
    chk_csr("t4_pend", 2'd1, 8'h06);
    irq_in = 8'h04;
    tick();
    irq_in = 8'h06;
    csr_wr(2'd1, 8'h02);
    chk_csr("t4_set_wins", 2'd1, 8'h06);
    chk("t4_no_irq", {15'b0, irq_r}, 16'h0);
    csr_wr(2'd1, 8'h06);
    chk_csr("t4_w1c", 2'd1, 8'h00);
    irq_in = '0;
    tick();

    // Fault, then double fault.
    fault_in = 1'b1;
    tick();
    fault_in = 1'b0;
    chk("t5_fault_r", {15'b0, fault_r}, 16'h1);
    chk_csr("t5_cause", 2'd3, 8'h09);
    chk("t5_vector", vector, 16'h0034);
    tick();
    chk("t5_fault_r_pulse", {15'b0, fault_r}, 16'h0);
    chk("t5_no_df", {15'b0, double_fault}, 16'h0);
    fault_in = 1'b1;
    tick();
    fault_in = 1'b0;
    chk_csr("t5_cause_df", 2'd3, 8'h89);
    chk("t5_df", {15'b0, double_fault}, 16'h1);
    reti();
    chk("t5_df_sticky", {15'b0, double_fault}, 16'h1);
    chk("t5_ie", {15'b0, ie}, 16'h1);

    // Async reset while PEND.
    irq_in = 8'h08;
    tick();
    tick();
    chk("t6_pend_irq_r", {15'b0, irq_r}, 16'h1);
    #2 reset = 1'b0;
    #1;
    chk("t6_irq_r", {15'b0, irq_r}, 16'h0);
    chk("t6_vector", vector, 16'h0010);
    chk("t6_ie", {15'b0, ie}, 16'h0);
    chk("t6_df", {15'b0, double_fault}, 16'h0);
    chk("t6_fault_r", {15'b0, fault_r}, 16'h0);
    chk_csr("t6_mask", 2'd0, 8'h00);
    chk_csr("t6_cause", 2'd3, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
